// File: rtl/program_loader_if.sv
// ---------------------------------------------------------------------------
// program_loader_if
// Valid/ready stream that carries the program image from the host or test
// source into the program loader. Each beat is one ROM word, packed as
// {instruction, operand}, and in_last marks the final word of the image.
//
// Signals
//   in_valid  master -> slave  a word is offered this cycle
//   in_ready  slave  -> master the loader takes the word at the next edge
//   in_word   master -> slave  {instr[INSTR_W-1:0], data[DATA_W-1:0]}
//   in_last   master -> slave  final word of the image
//
// Modports
//   master  the stream source (host or testbench)
//   slave   the program loader
// ---------------------------------------------------------------------------
interface program_loader_if #(
  parameter int INSTR_W = 3,
  parameter int DATA_W  = 4
) ();

  logic                       in_valid;
  logic                       in_ready;
  logic [INSTR_W+DATA_W-1:0]  in_word;
  logic                       in_last;

  modport master (
    output in_valid,
    output in_word,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_word,
    input  in_last,
    output in_ready
  );

endinterface

// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
// Write side of the CPU instruction/data ROM. A program image arrives over a
// valid/ready stream and is stored one word per entry as {instruction,
// operand}. The CPU is held in NOP (all-zero read data) until a complete
// image is present. A short image is padded with NOP words up to the top
// entry before the CPU is released.
//
// Ports
//   clock                  system clock, rising edge
//   reset_n                asynchronous active-low reset
//   start                  begin a (re)load; sampled in IDLE or RUN only
//   in_if                  image stream (slave side of program_loader_if)
//   count                  CPU read address (program counter)
//   controllerInstruction  instruction stored at count, 0 unless running
//   inX                    operand stored at count, 0 unless running
//   cpu_run                high while the CPU may execute
//   load_done              one-cycle pulse on the first running cycle
//   load_err               sticky; the image reached DEPTH without in_last
//   words_loaded           number of words accepted in the last load
// ---------------------------------------------------------------------------
module program_loader #(
  parameter int ADDR_W  = 3,
  parameter int INSTR_W = 3,
  parameter int DATA_W  = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  program_loader_if.slave     in_if,
  input  logic [ADDR_W-1:0]   count,
  output logic [INSTR_W-1:0]  controllerInstruction,
  output logic [DATA_W-1:0]   inX,
  output logic                cpu_run,
  output logic                load_done,
  output logic                load_err,
  output logic [ADDR_W:0]     words_loaded
);

  localparam int DEPTH  = 2 ** ADDR_W;
  localparam int WORD_W = INSTR_W + DATA_W;

  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    FILL,
    RUN
  } state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   mem_q [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     words_loaded_q, words_loaded_d;
  logic                load_err_q, load_err_d;
  logic                load_done_q, load_done_d;

  logic                startLoad;
  logic                transfer;
  logic                atLastEntry;
  logic                memWe;
  logic [WORD_W-1:0]   memWdata;
  logic [WORD_W-1:0]   rdWord;

  // start only counts in IDLE and RUN; a word only moves while in LOAD,
  // where in_ready is high by construction.
  assign startLoad   = start && ((state_q == IDLE) || (state_q == RUN));
  assign transfer    = (state_q == LOAD) && in_if.in_valid;
  assign atLastEntry = (wr_ptr_q == PTR_LAST);

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Reaching the top entry always ends the load, whether
  // the image ended there or was truncated, so the write pointer never wraps.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        if (transfer) begin
          if (atLastEntry)          state_d = RUN;
          else if (in_if.in_last)   state_d = FILL;
        end
      end
      FILL: begin
        if (atLastEntry) state_d = RUN;
      end
      RUN: begin
        if (start) state_d = LOAD;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic. The read port is purely combinational so a program
  // counter change shows up in the same cycle; outside RUN the CPU sees NOP.
  always_comb begin
    in_if.in_ready = 1'b0;
    cpu_run        = 1'b0;
    rdWord         = '0;
    unique case (state_q)
      LOAD:    in_if.in_ready = 1'b1;
      RUN: begin
        cpu_run = 1'b1;
        rdWord  = mem_q[count];
      end
      default: ;
    endcase
  end

  assign {controllerInstruction, inX} = rdWord;
  assign load_done    = load_done_q;
  assign load_err     = load_err_q;
  assign words_loaded = words_loaded_q;

  // Datapath next values. FILL reuses the write pointer to pad the rest of
  // the ROM with zero words, which also wipes any stale image from an
  // earlier, longer load.
  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    words_loaded_d = words_loaded_q;
    load_err_d     = load_err_q;
    memWe          = transfer || (state_q == FILL);
    memWdata       = (state_q == FILL) ? '0 : in_if.in_word;

    if (startLoad) begin
      wr_ptr_d       = '0;
      words_loaded_d = '0;
      load_err_d     = 1'b0;
    end

    if (memWe && !atLastEntry) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    if (transfer) begin
      words_loaded_d = words_loaded_q + CNT_ONE;
      if (atLastEntry && !in_if.in_last) load_err_d = 1'b1;
    end

    load_done_d = (state_d == RUN) && (state_q != RUN);
  end

  // Datapath registers and the ROM itself. Reset clears the whole memory so
  // an interrupted load leaves nothing behind.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q       <= '0;
      words_loaded_q <= '0;
      load_err_q     <= 1'b0;
      load_done_q    <= 1'b0;
    end else begin
      if (memWe) begin
        mem_q[wr_ptr_q] <= memWdata;
      end
      wr_ptr_q       <= wr_ptr_d;
      words_loaded_q <= words_loaded_d;
      load_err_q     <= load_err_d;
      load_done_q    <= load_done_d;
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// ---------------------------------------------------------------------------
// tb_program_loader
// Self-checking bench for program_loader. Every accepted image word is pushed
// onto a queue as it is driven and popped when the ROM is read back through
// the CPU port once the loader releases the CPU.
// ---------------------------------------------------------------------------
module tb_program_loader;

  localparam int ADDR_W  = 3;
  localparam int INSTR_W = 3;
  localparam int DATA_W  = 4;
  localparam int DEPTH   = 2 ** ADDR_W;
  localparam int WORD_W  = INSTR_W + DATA_W;

  logic                clock = 1'b0;
  logic                reset_n;
  logic                start;
  logic [ADDR_W-1:0]   count;
  logic [INSTR_W-1:0]  controllerInstruction;
  logic [DATA_W-1:0]   inX;
  logic                cpu_run;
  logic                load_done;
  logic                load_err;
  logic [ADDR_W:0]     words_loaded;

  int                  checks   = 0;
  int                  failures = 0;
  logic [WORD_W-1:0]   expQ [$];

  program_loader_if #(.INSTR_W(INSTR_W), .DATA_W(DATA_W)) in_if ();

  program_loader #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W),
    .DATA_W  (DATA_W)
  ) dut (
    .clock                 (clock),
    .reset_n               (reset_n),
    .start                 (start),
    .in_if                 (in_if),
    .count                 (count),
    .controllerInstruction (controllerInstruction),
    .inX                   (inX),
    .cpu_run               (cpu_run),
    .load_done             (load_done),
    .load_err              (load_err),
    .words_loaded          (words_loaded)
  );

  // 10 ns clock.
  always #5 clock = ~clock;

  // Safety net so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // One-cycle start pulse; returns 1 ns after the edge that samples it.
  task automatic pulseStart();
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
  endtask

  // Offer one word for exactly one edge and record it as expected ROM data.
  task automatic sendWord(input logic [WORD_W-1:0] w, input logic last);
    @(negedge clock);
    in_if.in_valid = 1'b1;
    in_if.in_word  = w;
    in_if.in_last  = last;
    expQ.push_back(w);
    @(posedge clock);
    #1;
    in_if.in_valid = 1'b0;
    in_if.in_last  = 1'b0;
  endtask

  // Idle cycles with in_valid low; word and last carry junk that must be ignored.
  task automatic gapCycles(input int n);
    repeat (n) begin
      @(negedge clock);
      in_if.in_valid = 1'b0;
      in_if.in_word  = WORD_W'($urandom);
      in_if.in_last  = 1'b1;
    end
  endtask

  // Count edges until load_done is seen, bounded by maxCycles.
  task automatic waitDone(input int maxCycles, output int cycles, output bit seen);
    cycles = 0;
    seen   = load_done;
    while (!seen && cycles < maxCycles) begin
      @(posedge clock);
      #1;
      cycles++;
      seen = load_done;
    end
  endtask

  task automatic test_reset();
    reset_n        = 1'b0;
    start          = 1'b1;
    in_if.in_valid = 1'b1;
    in_if.in_word  = 7'h7F;
    in_if.in_last  = 1'b1;
    count          = '0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (in_if.in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_in_ready: got %0b expected 0", in_if.in_ready);
    end
    checks++;
    if (cpu_run !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_cpu_run: got %0b expected 0", cpu_run);
    end
    checks++;
    if (load_done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_load_done: got %0b expected 0", load_done);
    end
    checks++;
    if (load_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_load_err: got %0b expected 0", load_err);
    end
    checks++;
    if (words_loaded !== '0) begin
      failures++;
      $display("[TB] FAIL reset_words_loaded: got %0d expected 0", words_loaded);
    end
    for (int i = 0; i < DEPTH; i++) begin
      count = ADDR_W'(i);
      #1;
      checks++;
      if ({controllerInstruction, inX} !== 7'h00) begin
        failures++;
        $display("[TB] FAIL reset_read[%0d]: got %0h expected 0", i, {controllerInstruction, inX});
      end
    end
    @(negedge clock);
    start          = 1'b0;
    in_if.in_valid = 1'b0;
    in_if.in_last  = 1'b0;
    reset_n        = 1'b1;
  endtask

  task automatic test_short_image();
    int                cycles;
    bit                seen;
    logic [WORD_W-1:0] exp;
    expQ.delete();
    pulseStart();
    checks++;
    if (in_if.in_ready !== 1'b1 || cpu_run !== 1'b0) begin
      failures++;
      $display("[TB] FAIL short_load_state: got ready=%0b run=%0b expected ready=1 run=0", in_if.in_ready, cpu_run);
    end
    sendWord(7'h15, 1'b0);
    sendWord(7'h2A, 1'b0);
    sendWord(7'h33, 1'b1);
    waitDone(20, cycles, seen);
    checks++;
    if (!seen || cycles != DEPTH - 3) begin
      failures++;
      $display("[TB] FAIL short_fill_latency: got seen=%0b edges=%0d expected seen=1 edges=%0d", seen, cycles, DEPTH - 3);
    end
    checks++;
    if (cpu_run !== 1'b1 || words_loaded !== 4'd3 || load_err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL short_status: got run=%0b words=%0d err=%0b expected run=1 words=3 err=0", cpu_run, words_loaded, load_err);
    end
    for (int i = 0; i < DEPTH; i++) begin
      count = ADDR_W'(i);
      exp   = (i < 3) ? expQ.pop_front() : 7'h00;
      #1;
      checks++;
      if ({controllerInstruction, inX} !== exp) begin
        failures++;
        $display("[TB] FAIL short_read[%0d]: got %0h expected %0h", i, {controllerInstruction, inX}, exp);
      end
    end
    @(posedge clock);
    #1;
    checks++;
    if (load_done !== 1'b0 || cpu_run !== 1'b1) begin
      failures++;
      $display("[TB] FAIL short_done_pulse: got done=%0b run=%0b expected done=0 run=1", load_done, cpu_run);
    end
  endtask

  task automatic test_backpressure();
    int                cycles;
    bit                seen;
    logic [WORD_W-1:0] exp;
    expQ.delete();
    pulseStart();
    for (int i = 0; i < DEPTH; i++) begin
      gapCycles(i % 3);
      sendWord(WORD_W'($urandom), (i == DEPTH - 1));
    end
    waitDone(20, cycles, seen);
    checks++;
    if (!seen || cycles != 0) begin
      failures++;
      $display("[TB] FAIL bp_latency: got seen=%0b edges=%0d expected seen=1 edges=0", seen, cycles);
    end
    checks++;
    if (load_err !== 1'b0 || words_loaded !== 4'd8) begin
      failures++;
      $display("[TB] FAIL bp_status: got err=%0b words=%0d expected err=0 words=8", load_err, words_loaded);
    end
    for (int i = 0; i < DEPTH; i++) begin
      count = ADDR_W'(i);
      exp   = expQ.pop_front();
      #1;
      checks++;
      if ({controllerInstruction, inX} !== exp) begin
        failures++;
        $display("[TB] FAIL bp_read[%0d]: got %0h expected %0h", i, {controllerInstruction, inX}, exp);
      end
    end
  endtask

  task automatic test_overflow();
    int                cycles;
    bit                seen;
    logic [WORD_W-1:0] exp;
    expQ.delete();
    pulseStart();
    for (int i = 0; i < DEPTH; i++) begin
      sendWord(WORD_W'($urandom), 1'b0);
    end
    waitDone(20, cycles, seen);
    checks++;
    if (!seen || cycles != 0) begin
      failures++;
      $display("[TB] FAIL ovf_latency: got seen=%0b edges=%0d expected seen=1 edges=0", seen, cycles);
    end
    checks++;
    if (load_err !== 1'b1 || words_loaded !== 4'd8) begin
      failures++;
      $display("[TB] FAIL ovf_status: got err=%0b words=%0d expected err=1 words=8", load_err, words_loaded);
    end
    @(negedge clock);
    in_if.in_valid = 1'b1;
    in_if.in_word  = 7'h55;
    in_if.in_last  = 1'b0;
    #1;
    checks++;
    if (in_if.in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ovf_ninth_ready: got %0b expected 0", in_if.in_ready);
    end
    @(posedge clock);
    #1;
    in_if.in_valid = 1'b0;
    checks++;
    if (words_loaded !== 4'd8) begin
      failures++;
      $display("[TB] FAIL ovf_ninth_count: got %0d expected 8", words_loaded);
    end
    for (int i = 0; i < DEPTH; i++) begin
      count = ADDR_W'(i);
      exp   = expQ.pop_front();
      #1;
      checks++;
      if ({controllerInstruction, inX} !== exp) begin
        failures++;
        $display("[TB] FAIL ovf_read[%0d]: got %0h expected %0h", i, {controllerInstruction, inX}, exp);
      end
    end
  endtask

  task automatic test_reload();
    int                cycles;
    bit                seen;
    logic [WORD_W-1:0] exp;
    expQ.delete();
    count = 3'd1;
    pulseStart();
    checks++;
    if (cpu_run !== 1'b0 || {controllerInstruction, inX} !== 7'h00) begin
      failures++;
      $display("[TB] FAIL reload_release: got run=%0b data=%0h expected run=0 data=0", cpu_run, {controllerInstruction, inX});
    end
    checks++;
    if (load_err !== 1'b0 || words_loaded !== 4'd0 || in_if.in_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reload_setup: got err=%0b words=%0d ready=%0b expected err=0 words=0 ready=1", load_err, words_loaded, in_if.in_ready);
    end
    sendWord(7'h6B, 1'b0);
    sendWord(7'h19, 1'b1);
    waitDone(20, cycles, seen);
    checks++;
    if (!seen || cycles != DEPTH - 2) begin
      failures++;
      $display("[TB] FAIL reload_latency: got seen=%0b edges=%0d expected seen=1 edges=%0d", seen, cycles, DEPTH - 2);
    end
    for (int i = 0; i < DEPTH; i++) begin
      count = ADDR_W'(i);
      exp   = (i < 2) ? expQ.pop_front() : 7'h00;
      #1;
      checks++;
      if ({controllerInstruction, inX} !== exp) begin
        failures++;
        $display("[TB] FAIL reload_read[%0d]: got %0h expected %0h", i, {controllerInstruction, inX}, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    int cycles;
    bit seen;
    expQ.delete();
    pulseStart();
    sendWord(7'h44, 1'b0);
    sendWord(7'h22, 1'b1);
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (in_if.in_ready !== 1'b0 || cpu_run !== 1'b0 || load_done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL arst_outputs: got ready=%0b run=%0b done=%0b expected all 0", in_if.in_ready, cpu_run, load_done);
    end
    checks++;
    if (words_loaded !== 4'd0 || load_err !== 1'b0 || {controllerInstruction, inX} !== 7'h00) begin
      failures++;
      $display("[TB] FAIL arst_status: got words=%0d err=%0b data=%0h expected all 0", words_loaded, load_err, {controllerInstruction, inX});
    end
    @(negedge clock);
    reset_n = 1'b1;
    waitDone(12, cycles, seen);
    checks++;
    if (seen || cpu_run !== 1'b0 || in_if.in_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL arst_stays_idle: got done=%0b run=%0b ready=%0b expected all 0", seen, cpu_run, in_if.in_ready);
    end
  endtask

  initial begin
    reset_n        = 1'b0;
    start          = 1'b0;
    count          = '0;
    in_if.in_valid = 1'b0;
    in_if.in_word  = '0;
    in_if.in_last  = 1'b0;
    test_reset();
    test_short_image();
    test_backpressure();
    test_overflow();
    test_reload();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
